// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control FSM: instruction sequencing, memory/multiplier wait timeout, halt/trap.
// Define MC_CU_MUL_EN to enable the multi-cycle mul path (EXR -> MULW -> WBA); otherwise mul traps.
module mc_control_unit #(
    parameter int OPC_W    = 6,
    parameter int ALUOP_W  = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               mul_done,
    output logic               imem_req,
    output logic               ir_wre,
    output logic               pc_wre,
    output logic               reg_wre,
    output logic               alu_src_b,
    output logic               ext_sel,
    output logic               mem2reg,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               mul_start,
    output logic               halted,
    output logic               trap,
    output logic [1:0]         pc_src,
    output logic [1:0]         reg_dst,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state
);

`ifdef MC_CU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_EXR = 4'd2, S_EXB = 4'd3, S_EXM = 4'd4, S_MEM = 4'd5,
        S_WBA = 4'd6, S_WBL = 4'd7, S_HALT = 4'd8, S_TRAP = 4'd9, S_MULW = 4'd10
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6'b000001);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6'b010000);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(6'b010001);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(6'b010010);
    localparam logic [OPC_W-1:0] OP_SLL  = OPC_W'(6'b011000);
    localparam logic [OPC_W-1:0] OP_MOVE = OPC_W'(6'b100000);
    localparam logic [OPC_W-1:0] OP_SLT  = OPC_W'(6'b100111);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(6'b101000);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b110000);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b110001);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b110100);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b111000);
    localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(6'b111001);
    localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(6'b111010);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(6'b111111);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    function automatic logic [ALUOP_W-1:0] alu_op_of(input logic [OPC_W-1:0] op);
        case (op)
            OP_SUB:         return ALUOP_W'(3'b001);
            OP_SLT:         return ALUOP_W'(3'b010);
            OP_SLL:         return ALUOP_W'(3'b100);
            OP_OR, OP_ORI:  return ALUOP_W'(3'b101);
            OP_AND:         return ALUOP_W'(3'b110);
            OP_MUL:         return ALUOP_W'(3'b111);
            default:        return ALUOP_W'(3'b000);
        endcase
    endfunction

    state_t     state_q, state_d, cur;
    logic [7:0] wait_q, wait_d;
    logic       is_imm, is_alu, is_sw, is_lw, is_mul, waiting, wait_hit;

    always_comb begin
        is_imm = (opcode == OP_ADDI) || (opcode == OP_ORI);
        is_alu = is_imm || (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR) ||
                 (opcode == OP_AND) || (opcode == OP_SLL) || (opcode == OP_MOVE) ||
                 (opcode == OP_SLT);
        is_sw  = (opcode == OP_SW);
        is_lw  = (opcode == OP_LW);
        is_mul = (opcode == OP_MUL);
    end

    // The wait counter only advances while an access is outstanding; a state change restarts it.
    assign waiting  = (state_q == S_IF) || (state_q == S_MEM) || (state_q == S_MULW);
    assign wait_hit = (wait_q == WAIT_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:   if (imem_ready) state_d = S_ID; else if (wait_hit) state_d = S_TRAP;
            S_ID: begin
                if (is_alu || (MUL_EN && is_mul))                         state_d = S_EXR;
                else if (opcode == OP_BEQ)                                state_d = S_EXB;
                else if (is_sw || is_lw)                                  state_d = S_EXM;
                else if (opcode == OP_J || opcode == OP_JR || opcode == OP_JAL) state_d = S_IF;
                else if (opcode == OP_HALT)                               state_d = S_HALT;
                else                                                      state_d = S_TRAP;
            end
            S_EXR:  state_d = (MUL_EN && is_mul) ? S_MULW : S_WBA;
            S_EXB, S_WBA, S_WBL: state_d = S_IF;
            S_EXM:  state_d = S_MEM;
            S_MEM:  if (dmem_ready) state_d = is_sw ? S_IF : S_WBL; else if (wait_hit) state_d = S_TRAP;
            S_MULW: if (mul_done) state_d = S_WBA; else if (wait_hit) state_d = S_TRAP;
            S_HALT, S_TRAP: state_d = state_q;
            default: state_d = S_TRAP;
        endcase
        if (state_d != state_q) wait_d = 8'd0;
        else if (waiting)       wait_d = wait_q + 8'd1;
        else                    wait_d = wait_q;
    end

    // Outputs decode as IF while reset is held so an abandoned instruction writes nothing.
    assign cur   = reset ? S_IF : state_q;
    assign state = cur;

    always_comb begin
        imem_req  = 1'b0;  ir_wre   = 1'b0;  pc_wre   = 1'b0;  reg_wre = 1'b0;
        alu_src_b = 1'b0;  ext_sel  = 1'b0;  mem2reg  = 1'b0;  dmem_req = 1'b0;
        dmem_we   = 1'b0;  mul_start = 1'b0; halted   = 1'b0;  trap    = 1'b0;
        pc_src    = 2'b00; reg_dst  = 2'b00; alu_op   = '0;
        case (cur)
            S_IF: begin
                imem_req = 1'b1;
                ir_wre   = imem_ready;
            end
            S_ID: begin
                ext_sel = is_imm || is_sw || is_lw || (opcode == OP_BEQ);
                if (opcode == OP_J || opcode == OP_JAL) begin
                    pc_wre = 1'b1;
                    pc_src = 2'b11;
                end else if (opcode == OP_JR) begin
                    pc_wre = 1'b1;
                    pc_src = 2'b10;
                end
                reg_wre = (opcode == OP_JAL);
            end
            S_EXR: begin
                alu_op    = alu_op_of(opcode);
                alu_src_b = is_imm || (opcode == OP_SLL);
                mul_start = MUL_EN && is_mul;
            end
            S_WBA: begin
                reg_wre = 1'b1;
                pc_wre  = 1'b1;
                reg_dst = is_imm ? 2'b01 : 2'b10;
            end
            S_EXB: begin
                alu_op = ALUOP_W'(3'b001);
                pc_wre = 1'b1;
                pc_src = zero ? 2'b01 : 2'b00;
            end
            S_EXM: alu_src_b = 1'b1;
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = is_sw;
                alu_src_b = 1'b1;
                pc_wre    = is_sw && dmem_ready;
            end
            S_WBL: begin
                mem2reg = 1'b1;
                reg_wre = 1'b1;
                reg_dst = 2'b01;
                pc_wre  = 1'b1;
            end
            S_MULW: alu_op = ALUOP_W'(3'b111);
            S_HALT: halted = 1'b1;
            S_TRAP: trap   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench: each instruction is expanded into an expected per-cycle trace from the ISA rules.
module tb_mc_control_unit;
    localparam int WM = 15;

    logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0, mul_done = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic imem_req, ir_wre, pc_wre, reg_wre, alu_src_b, ext_sel, mem2reg, dmem_req, dmem_we;
    logic mul_start, halted, trap;
    logic [1:0] pc_src, reg_dst;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [22:0] obs_v;

    always #5 clk = ~clk;

    mc_control_unit #(.OPC_W(6), .ALUOP_W(3), .WAIT_MAX(WM)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .mul_done(mul_done), .imem_req(imem_req), .ir_wre(ir_wre),
        .pc_wre(pc_wre), .reg_wre(reg_wre), .alu_src_b(alu_src_b), .ext_sel(ext_sel),
        .mem2reg(mem2reg), .dmem_req(dmem_req), .dmem_we(dmem_we), .mul_start(mul_start),
        .halted(halted), .trap(trap), .pc_src(pc_src), .reg_dst(reg_dst), .alu_op(alu_op),
        .state(state)
    );

    assign obs_v = {imem_req, ir_wre, pc_wre, reg_wre, alu_src_b, ext_sel, mem2reg, dmem_req,
                    dmem_we, mul_start, halted, trap, pc_src, reg_dst, alu_op, state};

    localparam int IMREQ = 1 << 22, IRWRE = 1 << 21, PCWRE = 1 << 20, REGWRE = 1 << 19;
    localparam int SRCB = 1 << 18, EXTS = 1 << 17, M2R = 1 << 16, DREQ = 1 << 15, DWE = 1 << 14;
    localparam int MST = 1 << 13, HLT = 1 << 12, TRP = 1 << 11;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR = 6'b010000, OP_AND = 6'b010001, OP_ORI = 6'b010010;
    localparam logic [5:0] OP_SLL = 6'b011000, OP_MOVE = 6'b100000, OP_SLT = 6'b100111;
    localparam logic [5:0] OP_MUL = 6'b101000, OP_SW = 6'b110000, OP_LW = 6'b110001;
    localparam logic [5:0] OP_BEQ = 6'b110100, OP_J = 6'b111000, OP_JR = 6'b111001;
    localparam logic [5:0] OP_JAL = 6'b111010, OP_HALT = 6'b111111;

    function automatic int PS(input int v); return v << 9; endfunction
    function automatic int RD(input int v); return v << 7; endfunction
    function automatic int AL(input int v); return v << 4; endfunction

    function automatic int alu_of(input logic [5:0] op);
        case (op)
            OP_SUB: return 1;
            OP_SLT: return 2;
            OP_SLL: return 4;
            OP_OR, OP_ORI: return 5;
            OP_AND: return 6;
            default: return 0;
        endcase
    endfunction

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       imr, dmr, mdn, z;
        int         exp;
    } cyc_t;

    cyc_t q[$];
    int total = 0, bad = 0, ncyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
        end
    endtask

    // which: 0 none, 1 imem_ready, 2 dmem_ready, 3 mul_done, 4 zero
    task automatic put_r(input logic [5:0] op, input int exp, input int which, input logic val);
        cyc_t c;
        c.rst = 1'b0; c.op = op; c.exp = exp;
        c.imr = 1'($urandom_range(1, 0)); c.dmr = 1'($urandom_range(1, 0));
        c.mdn = 1'($urandom_range(1, 0)); c.z = 1'($urandom_range(1, 0));
        case (which)
            1: c.imr = val;
            2: c.dmr = val;
            3: c.mdn = val;
            4: c.z = val;
            default: ;
        endcase
        q.push_back(c);
    endtask

    task automatic put(input logic [5:0] op, input int exp);
        put_r(op, exp, 0, 1'b0);
    endtask

    function automatic cyc_t rst_cyc(input logic [5:0] op);
        cyc_t c;
        c.rst = 1'b1; c.op = op;
        c.imr = 1'($urandom_range(1, 0)); c.dmr = 1'($urandom_range(1, 0));
        c.mdn = 1'($urandom_range(1, 0)); c.z = 1'($urandom_range(1, 0));
        c.exp = IMREQ | (c.imr ? IRWRE : 0);
        return c;
    endfunction

    // Ready held low for d cycles: the access times out once d exceeds the wait limit.
    task automatic wait_phase(input logic [5:0] op, input int d, input int which,
                              input int exp_low, input int exp_done, output bit trapped);
        int n;
        n = (d > WM) ? WM + 1 : d;
        for (int i = 0; i < n; i++) put_r(op, exp_low, which, 1'b0);
        trapped = (d > WM);
        if (!trapped) put_r(op, exp_done, which, 1'b1);
    endtask

    task automatic trap_tail(input logic [5:0] op);
        int n;
        n = 2 + int'($urandom_range(3, 0));
        for (int i = 0; i < n; i++) put(op, 9 | TRP);
        q.push_back(rst_cyc(op));
    endtask

    task automatic gen(input logic [5:0] op, input int di, input int dm, input int du,
                       input int zs, input int hold);
        bit tr, imm;
        int lowe;
        logic zv;
        wait_phase(op, di, 1, IMREQ, IMREQ | IRWRE, tr);
        if (tr) begin
            trap_tail(op);
            return;
        end
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT, OP_MOVE, OP_SLL, OP_ADDI, OP_ORI: begin
                imm = (op == OP_ADDI) || (op == OP_ORI);
                put(op, 1 | (imm ? EXTS : 0));
                put(op, 2 | AL(alu_of(op)) | ((imm || op == OP_SLL) ? SRCB : 0));
                put(op, 6 | REGWRE | PCWRE | RD(imm ? 1 : 2));
            end
            OP_BEQ: begin
                put(op, 1 | EXTS);
                zv = (zs < 0) ? 1'($urandom_range(1, 0)) : 1'(zs);
                put_r(op, 3 | AL(1) | PCWRE | PS(zv ? 1 : 0), 4, zv);
            end
            OP_SW, OP_LW: begin
                put(op, 1 | EXTS);
                put(op, 4 | SRCB);
                lowe = 5 | DREQ | SRCB | ((op == OP_SW) ? DWE : 0);
                wait_phase(op, dm, 2, lowe, lowe | ((op == OP_SW) ? PCWRE : 0), tr);
                if (tr) trap_tail(op);
                else if (op == OP_LW) put(op, 7 | M2R | REGWRE | RD(1) | PCWRE);
            end
            OP_J:   put(op, 1 | PCWRE | PS(3));
            OP_JR:  put(op, 1 | PCWRE | PS(2));
            OP_JAL: put(op, 1 | PCWRE | PS(3) | REGWRE | RD(0));
            OP_HALT: begin
                put(op, 1);
                for (int i = 0; i < hold; i++) put(op, 8 | HLT);
                q.push_back(rst_cyc(op));
            end
`ifdef MC_CU_MUL_EN
            OP_MUL: begin
                put(op, 1);
                put(op, 2 | AL(7) | MST);
                wait_phase(op, du, 3, 10 | AL(7), 10 | AL(7), tr);
                if (tr) trap_tail(op);
                else put(op, 6 | REGWRE | PCWRE | RD(2));
            end
`endif
            default: begin
                put(op, 1);
                trap_tail(op);
            end
        endcase
    endtask

    function automatic int rdel();
        int r;
        r = int'($urandom_range(9, 0));
        if (r < 6) return int'($urandom_range(2, 0));
        if (r < 9) return int'($urandom_range(4, 0));
        return WM - 1 + int'($urandom_range(2, 0));
    endfunction

    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            reset = c.rst; opcode = c.op; imem_ready = c.imr;
            dmem_ready = c.dmr; mul_done = c.mdn; zero = c.z;
            @(negedge clk);
            check($sformatf("cyc%0d_st%0d_op%02h", ncyc, c.exp & 15, c.op), int'(obs_v), c.exp);
            ncyc++;
        end
    endtask

    logic [5:0] ops [17] = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_MOVE,
                             OP_SLT, OP_MUL, OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT};

    initial begin
        int s, k;
        logic [5:0] op;
        repeat (2) @(posedge clk);
        q.push_back(rst_cyc(OP_ADD));
        q.push_back(rst_cyc(OP_ADD));
        gen(OP_ADD, 0, 0, 0, -1, 0);
        gen(OP_LW, 0, 3, 0, -1, 0);
        gen(OP_BEQ, 1, 0, 0, 1, 0);
        gen(OP_BEQ, 0, 0, 0, 0, 0);
        gen(OP_ADDI, 2, 0, 0, -1, 0);
        gen(OP_SW, 0, 1, 0, -1, 0);
        gen(OP_JAL, 0, 0, 0, -1, 0);
        gen(OP_ADD, WM, 0, 0, -1, 0);
        gen(OP_ADD, WM + 1, 0, 0, -1, 0);
        gen(OP_SW, 0, WM, 0, -1, 0);
        gen(OP_LW, 0, WM + 1, 0, -1, 0);
        gen(OP_HALT, 0, 0, 0, -1, 20);
        gen(6'b001111, 0, 0, 0, -1, 0);
        gen(OP_MUL, 0, 0, 5, -1, 0);
        gen(OP_SLL, 0, 0, 0, -1, 0);
        play();
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(15, 0) == 0) op = 6'($urandom_range(63, 0));
            else op = ops[$urandom_range(16, 0)];
            s = q.size();
            gen(op, rdel(), rdel(), rdel(), -1, 1 + int'($urandom_range(4, 0)));
            // Occasionally abandon the instruction with a reset in a random cycle.
            if ($urandom_range(7, 0) == 0 && q.size() > s) begin
                k = s + int'($urandom_range(q.size() - s - 1, 0));
                q[k] = rst_cyc(op);
                while (q.size() > k + 1) void'(q.pop_back());
            end
            play();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
